// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-lookahead adder/subtractor.
//
// WIDTH-bit operands are cut into NG = WIDTH/GROUP lookahead groups. Rank 0
// captures the operands (B already inverted for subtract) and the effective
// carry. Between rank k and rank k+1 group k is summed with full two-level
// lookahead. Its carry-out then moves on to the next rank. Result bits that
// are already done and operand bits that are still waiting travel along in
// skew registers. Latency is NG cycles from accept to out_valid, and
// throughput is one beat per cycle.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready = !out_valid | out_ready)
//   a, b, cin, sub        operands; sub=1 gives a-b and ignores cin
//   out_valid / out_ready result handshake; a stall freezes every rank
//   sum, cout             result modulo 2^WIDTH, carry out (sub: 1 = no borrow)
//   ovf                   signed overflow, present only with CLA_OVF_EN defined
//
// Optional feature macro: CLA_OVF_EN

// One GROUP-bit lookahead block. Each carry is written as a sum of products
// of g/p/c_i, so it synthesises to two logic levels and does not ripple.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a_i,
   input  logic [GROUP-1:0] b_i,
   input  logic             c_i,
   output logic [GROUP-1:0] s_o,
   output logic             c_o,
   output logic             c_msb_o
);
   logic [GROUP-1:0] p, g;
   logic [GROUP:0]   c;
   logic             term, prod;

   always_comb begin
      p    = a_i ^ b_i;
      g    = a_i & b_i;
      c    = '0;
      term = 1'b0;
      prod = 1'b0;
      c[0] = c_i;
      // c[i] = c_i&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] )
      for (int i = 1; i <= GROUP; i++) begin
         term = c_i;
         for (int m = 0; m < i; m++) term = term & p[m];
         for (int j = 0; j < i; j++) begin
            prod = g[j];
            for (int m = j + 1; m < i; m++) prod = prod & p[m];
            term = term | prod;
         end
         c[i] = term;
      end
   end

   assign s_o     = p ^ c[GROUP-1:0];
   assign c_o     = c[GROUP];
   assign c_msb_o = c[GROUP-1];
endmodule

module cla_pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int NG = WIDTH / GROUP;

   logic [NG:0]                 vld_pipe;
   logic [NG-1:0][WIDTH-1:0]    a_q, a_d, b_q, b_d;   // operand skew, rank 0..NG-1
   logic [NG:1][WIDTH-1:0]      s_q, s_d;             // partial result, rank 1..NG
   logic [NG:0]                 c_q, c_d;             // carry into group k at rank k
   logic [NG-1:0][GROUP-1:0]    gs;
   logic [NG-1:0]               gc, gm;
   logic                        advance;

   // The whole pipe moves as one. Bubbles are not squeezed out, so the
   // only back-pressure point is the output rank.
   assign advance  = !vld_pipe[NG] || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group #(.GROUP(GROUP)) u_grp (
         .a_i     (a_q[k][k*GROUP +: GROUP]),
         .b_i     (b_q[k][k*GROUP +: GROUP]),
         .c_i     (c_q[k]),
         .s_o     (gs[k]),
         .c_o     (gc[k]),
         .c_msb_o (gm[k])
      );
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      c_d    = c_q;
      a_d[0] = a;
      b_d[0] = sub ? ~b : b;
      c_d[0] = sub | cin;               // subtract forces the +1
      for (int k = 1; k < NG; k++) begin
         a_d[k] = a_q[k-1];
         b_d[k] = b_q[k-1];
      end
      s_d[1] = '0;
      for (int k = 1; k < NG; k++) s_d[k+1] = s_q[k];
      for (int k = 0; k < NG; k++) begin
         s_d[k+1][k*GROUP +: GROUP] = gs[k];
         c_d[k+1]                   = gc[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         c_q      <= '0;
      end else if (advance) begin
         vld_pipe <= {vld_pipe[NG-1:0], in_valid};
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         c_q      <= c_d;
      end
   end

   assign out_valid = vld_pipe[NG];
   assign sum       = s_q[NG];
   assign cout      = c_q[NG];

`ifdef CLA_OVF_EN
   logic ovf_q, ovf_d;

   // Signed overflow: the carry into the MSB differs from the carry out of it.
   assign ovf_d = gm[NG-1] ^ gc[NG-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          ovf_q <= 1'b0;
      else if (advance) ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

   // The last rank only reads its top group of operand bits. The MSB carry
   // taps are only used by the overflow logic.
   logic unused_bits;
   assign unused_bits = ^{a_q[NG-1], b_q[NG-1], gm};
endmodule

// File: tb/tb_cla_pipe_addsub.sv
module tb_cla_pipe_addsub;
   localparam int W  = 16;
   localparam int G  = 4;
   localparam int NG = W / G;

   logic         clk = 1'b0;
   logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
   logic [W-1:0] a, b, sum;
`ifdef CLA_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_pipe_addsub #(.WIDTH(W), .GROUP(G)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: {ovf, cout, sum}
   function automatic logic [17:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
      logic [W-1:0] be;
      logic [W:0]   r;
      logic         o;
      be = ms ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, be} + {16'd0, (ms | mc)};
      o  = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
      return {o, r};
   endfunction

   // One isolated beat: checks that it arrives exactly NG cycles after accept.
   task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < NG; i++) begin
         chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_vld"},  {31'd0, out_valid}, 32'd1);
      chk({tag, "_sum"},  {16'd0, sum}, {16'd0, es});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
`ifdef CLA_OVF_EN
      chk({tag, "_ovf"},  {31'd0, ovf}, {31'd0, eo});
`endif
      if (eo === 1'bx) $display("note: unknown ovf expectation in %s", tag);
   endtask

   logic [17:0] expq[$];
   logic [17:0] e;
   logic [W-1:0] sum_prev;
   bit           stall_prev;
   int           sent, rcvd, cyc;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_vld",  {31'd0, out_valid}, 32'd0);
      chk("rst_sum",  {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      rst = 1'b0;
      #1 chk("rst_rdy", {31'd0, in_ready}, 32'd1);

      // directed, hand-computed
      run_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("sub57",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("sub75",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
      run_one("cin",    16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_one("ovfadd", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_one("ovfsub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_one("grpbnd", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

      // streaming with two 3-cycle stalls
      sent = 0; rcvd = 0; cyc = 0; stall_prev = 0; sum_prev = '0;
      while ((sent < 200 || expq.size() > 0) && cyc < 1000) begin
         @(negedge clk);
         if (stall_prev) begin
            chk("hold_sum", {16'd0, sum}, {16'd0, sum_prev});
            chk("hold_vld", {31'd0, out_valid}, 32'd1);
         end
         out_ready = !((cyc >= 50 && cyc < 53) || (cyc >= 120 && cyc < 123));
         in_valid  = (sent < 200);
         a = W'($urandom); b = W'($urandom);
         cin = 1'($urandom); sub = 1'($urandom);
         #1;
         chk("in_ready", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
         if (out_valid && out_ready) begin
            chk("no_extra", {31'd0, expq.size() > 0}, 32'd1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("str_sum",  {16'd0, sum}, {16'd0, e[15:0]});
               chk("str_cout", {31'd0, cout}, {31'd0, e[16]});
`ifdef CLA_OVF_EN
               chk("str_ovf",  {31'd0, ovf}, {31'd0, e[17]});
`endif
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(a, b, cin, sub));
            sent++;
         end
         stall_prev = out_valid && !out_ready;
         sum_prev   = sum;
         cyc++;
      end
      in_valid = 1'b0;
      chk("str_bound", {31'd0, cyc < 1000}, 32'd1);
      chk("str_count", rcvd, 32'd200);

      // reset with beats in flight
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = W'(i + 1); b = W'(i + 7); cin = 1'b0; sub = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("mid_vld_pre", {31'd0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1 chk("mid_vld_rst", {31'd0, out_valid}, 32'd0);
      chk("mid_rdy_rst", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      run_one("postrst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
      @(negedge clk);
      chk("postrst_drain", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
